// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and the raster record carried down the alignment delay line.
package vga_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam logic VGA_SYNC_ACTIVE = 1'b0;
  localparam int CNT_W = 10;

  typedef struct packed {
    logic [CNT_W-1:0] hCount;
    logic [CNT_W-1:0] vCount;
    logic             active;
    logic             hs;
    logic             vs;
  } raster_t;

  // Blank raster record: origin, inactive, syncs at their idle level.
  function automatic raster_t idle_raster(input logic sync_active);
    idle_raster    = '0;
    idle_raster.hs = ~sync_active;
    idle_raster.vs = ~sync_active;
  endfunction
endpackage

// File: rtl/vga_timing.sv
// Stage 0 of the fetcher: raster counters, active-area flag and undelayed sync levels.
module vga_timing import vga_pkg::*; #(
  parameter int   H_ACTIVE    = VGA_H_ACTIVE,
  parameter int   H_FP        = VGA_H_FP,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BP        = VGA_H_BP,
  parameter int   V_ACTIVE    = VGA_V_ACTIVE,
  parameter int   V_FP        = VGA_V_FP,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BP        = VGA_V_BP,
  parameter logic SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
  input  logic    clk_i,
  input  logic    rst_i,
  output raster_t pos_o,
  output logic    lineEnd_o,
  output logic    frameEnd_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [CNT_W-1:0] hCount_q, hCount_d, vCount_q, vCount_d;
  logic hsOn, vsOn;

  assign lineEnd_o  = hCount_q == CNT_W'(H_TOTAL-1);
  assign frameEnd_o = lineEnd_o && vCount_q == CNT_W'(V_TOTAL-1);

  always_comb begin
    hCount_d = lineEnd_o ? '0 : hCount_q + 1'b1;
    vCount_d = vCount_q;
    if (lineEnd_o) vCount_d = frameEnd_o ? '0 : vCount_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hCount_q <= '0;
      vCount_q <= '0;
    end else begin
      hCount_q <= hCount_d;
      vCount_q <= vCount_d;
    end
  end

  assign hsOn = hCount_q >= CNT_W'(H_ACTIVE+H_FP) && hCount_q < CNT_W'(H_ACTIVE+H_FP+H_SYNC);
  assign vsOn = vCount_q >= CNT_W'(V_ACTIVE+V_FP) && vCount_q < CNT_W'(V_ACTIVE+V_FP+V_SYNC);

  always_comb begin
    pos_o.hCount = hCount_q;
    pos_o.vCount = vCount_q;
    pos_o.active = hCount_q < CNT_W'(H_ACTIVE) && vCount_q < CNT_W'(V_ACTIVE);
    pos_o.hs     = hsOn ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    pos_o.vs     = vsOn ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end
endmodule

// File: rtl/frame_fetcher.sv
// Raster-driven framebuffer reader: multiplier-free scaled address generation plus
// delay lines that align videoOn/color_index and the syncs with the downstream printer.
module frame_fetcher import vga_pkg::*; #(
  parameter int   H_ACTIVE    = VGA_H_ACTIVE,
  parameter int   H_FP        = VGA_H_FP,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BP        = VGA_H_BP,
  parameter int   V_ACTIVE    = VGA_V_ACTIVE,
  parameter int   V_FP        = VGA_V_FP,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BP        = VGA_V_BP,
  parameter int   SCALE       = 2,
  parameter int   FB_W        = 320,
  parameter int   FB_H        = 240,
  parameter int   ADDR_W      = 17,
  parameter int   PRINTER_LAT = 2,
  parameter logic SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
  input  logic              vgaClk,
  input  logic              rst,
  output logic [ADDR_W-1:0] fbAddr,
  input  logic [7:0]        fbData,
  output logic              videoOn,
  output logic [7:0]        color_index,
  output logic              hsync,
  output logic              vsync,
  output logic              frameStart
);
  localparam int DLY   = 2 + PRINTER_LAT;
  localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam raster_t RST_POS = idle_raster(SYNC_ACTIVE);

  if (FB_W*SCALE != H_ACTIVE) begin : g_bad_w
    $error("frame_fetcher: FB_W*SCALE must equal H_ACTIVE");
  end
  if (FB_H*SCALE != V_ACTIVE) begin : g_bad_h
    $error("frame_fetcher: FB_H*SCALE must equal V_ACTIVE");
  end
  if (FB_W*FB_H > 2**ADDR_W) begin : g_bad_a
    $error("frame_fetcher: framebuffer does not fit in ADDR_W");
  end
  if ((SCALE & (SCALE-1)) != 0) begin : g_bad_s
    $error("frame_fetcher: SCALE must be a power of two");
  end

  raster_t pos;
  logic    lineEnd, frameEnd;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_ACTIVE(SYNC_ACTIVE)
  ) u_timing (
    .clk_i(vgaClk), .rst_i(rst), .pos_o(pos), .lineEnd_o(lineEnd), .frameEnd_o(frameEnd)
  );

  logic [SUB_W-1:0]  colSub_q, colSub_d, lineSub_q, lineSub_d;
  logic [ADDR_W-1:0] colCnt_q, colCnt_d, lineBase_q, lineBase_d, fbAddr_q, fbAddr_d;
  logic              frameStart_q;
  raster_t           pipe_q [1:DLY];

  // colSub/lineSub count replicated pixels/lines so the address advances once per SCALE.
  always_comb begin
    colSub_d   = colSub_q;
    colCnt_d   = colCnt_q;
    lineSub_d  = lineSub_q;
    lineBase_d = lineBase_q;
    fbAddr_d   = fbAddr_q;
    if (pos.active) begin
      fbAddr_d = lineBase_q + colCnt_q;
      colSub_d = colSub_q + 1'b1;
      if (colSub_q == SUB_W'(SCALE-1)) begin
        colSub_d = '0;
        colCnt_d = colCnt_q + 1'b1;
      end
    end
    if (lineEnd) begin
      colSub_d = '0;
      colCnt_d = '0;
      if (pos.vCount < CNT_W'(V_ACTIVE)) begin
        lineSub_d = lineSub_q + 1'b1;
        if (lineSub_q == SUB_W'(SCALE-1)) begin
          lineSub_d  = '0;
          lineBase_d = lineBase_q + ADDR_W'(FB_W);
        end
      end
    end
    if (frameEnd) begin
      lineSub_d  = '0;
      lineBase_d = '0;
    end
  end

  always_ff @(posedge vgaClk) begin
    if (rst) begin
      colSub_q     <= '0;
      colCnt_q     <= '0;
      lineSub_q    <= '0;
      lineBase_q   <= '0;
      fbAddr_q     <= '0;
      frameStart_q <= 1'b0;
      for (int i = 1; i <= DLY; i++) pipe_q[i] <= RST_POS;
    end else begin
      colSub_q     <= colSub_d;
      colCnt_q     <= colCnt_d;
      lineSub_q    <= lineSub_d;
      lineBase_q   <= lineBase_d;
      fbAddr_q     <= fbAddr_d;
      frameStart_q <= pos.hCount == '0 && pos.vCount == '0;
      pipe_q[1]    <= pos;
      for (int i = 2; i <= DLY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Memory read data lands in the same cycle as stage 2 of the delay line.
  assign fbAddr      = fbAddr_q;
  assign frameStart  = frameStart_q;
  assign videoOn     = pipe_q[2].active;
  assign color_index = videoOn ? fbData : 8'd0;
  assign hsync       = pipe_q[DLY].hs;
  assign vsync       = pipe_q[DLY].vs;

  logic unused_pipe;
  always_comb begin
    unused_pipe = 1'b0;
    for (int i = 1; i <= DLY; i++) unused_pipe = unused_pipe ^ (^pipe_q[i]);
  end
endmodule

// File: tb/tb_frame_fetcher.sv
// Directed bench for frame_fetcher on a shrunken 24x13 raster (16x8 active, 8x4 framebuffer).
module tb_frame_fetcher;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8, VF = 1, VS = 2, VB = 2;
  localparam int SC = 2, FW = 8, FH = 4, AW = 17, PL = 2;
  localparam int NS = 340;

  logic          vgaClk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] fbAddr;
  logic [7:0]    fbData = 8'd0;
  logic          videoOn, hsync, vsync, frameStart;
  logic [7:0]    color_index;

  int n_tot = 0;
  int n_bad = 0;

  logic [31:0] fa [0:NS];
  logic [31:0] ci [0:NS];
  logic        vo [0:NS];
  logic        hs [0:NS];
  logic        vs [0:NS];
  logic        fs [0:NS];

  frame_fetcher #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SCALE(SC), .FB_W(FW), .FB_H(FH), .ADDR_W(AW), .PRINTER_LAT(PL), .SYNC_ACTIVE(1'b0)
  ) dut (
    .vgaClk(vgaClk), .rst(rst), .fbAddr(fbAddr), .fbData(fbData), .videoOn(videoOn),
    .color_index(color_index), .hsync(hsync), .vsync(vsync), .frameStart(frameStart)
  );

  always #5 vgaClk = ~vgaClk;

  // Registered-read memory whose contents equal the low address byte.
  always @(posedge vgaClk) fbData <= fbAddr[7:0];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".fbAddr"},      32'(fbAddr), 32'd0);
    chk({tag, ".videoOn"},     32'(videoOn), 32'd0);
    chk({tag, ".color_index"}, 32'(color_index), 32'd0);
    chk({tag, ".frameStart"},  32'(frameStart), 32'd0);
    chk({tag, ".hsync"},       32'(hsync), 32'd1);
    chk({tag, ".vsync"},       32'(vsync), 32'd1);
  endtask

  // Sample s is taken at the negedge s cycles after rst was dropped.
  task automatic capture(input int n);
    for (int s = 1; s <= n; s++) begin
      @(negedge vgaClk);
      fa[s] = 32'(fbAddr);
      ci[s] = 32'(color_index);
      vo[s] = videoOn;
      hs[s] = hsync;
      vs[s] = vsync;
      fs[s] = frameStart;
    end
  endtask

  task automatic chk_start(input string tag);
    int e_fa [5] = '{0, 0, 1, 1, 2};
    int e_fs [5] = '{1, 0, 0, 0, 0};
    int e_vo [5] = '{0, 1, 1, 1, 1};
    int e_ci [5] = '{0, 0, 0, 1, 1};
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s.fbAddr[%0d]", tag, k+1),     fa[k+1], e_fa[k]);
      chk($sformatf("%s.frameStart[%0d]", tag, k+1), 32'(fs[k+1]), e_fs[k]);
      chk($sformatf("%s.videoOn[%0d]", tag, k+1),    32'(vo[k+1]), e_vo[k]);
      chk($sformatf("%s.color[%0d]", tag, k+1),      ci[k+1], e_ci[k]);
    end
  endtask

  initial begin
    int cnt, first, first2, errz, errm;
    rst = 1'b1;
    repeat (3) @(negedge vgaClk);
    check_reset("rst0");
    rst = 1'b0;
    capture(NS);

    chk_start("boot");

    cnt = 0; first = -1;
    for (int s = 1; s <= 24; s++) if (vo[s]) begin cnt++; if (first < 0) first = s; end
    chk("line0.videoOn_cycles", cnt, 16);
    chk("line0.videoOn_first", first, 2);

    cnt = 0; first = -1;
    for (int s = 1; s <= 30; s++) if (!hs[s]) begin cnt++; if (first < 0) first = s; end
    chk("line0.hsync_cycles", cnt, 3);
    chk("line0.hsync_first", first, 22);

    chk("line1.start_addr", fa[25], 0);
    chk("line2.start_addr", fa[49], 8);
    chk("line7.start_addr", fa[169], 24);
    chk("last_pixel_addr", fa[184], 31);
    chk("blank_hold_addr", fa[200], 31);
    chk("frame2.start_addr", fa[313], 0);

    cnt = 0; first = -1; first2 = -1;
    for (int s = 1; s <= NS; s++) if (fs[s]) begin
      cnt++;
      if (first < 0) first = s; else if (first2 < 0) first2 = s;
    end
    chk("frameStart_pulses", cnt, 2);
    chk("frameStart_period", first2 - first, 312);

    cnt = 0; first = -1;
    for (int s = 1; s <= 312; s++) if (!vs[s]) begin cnt++; if (first < 0) first = s; end
    chk("vsync_cycles", cnt, 48);
    chk("vsync_first", first, 220);

    cnt = 0;
    for (int s = 1; s <= 312; s++) if (vo[s]) cnt++;
    chk("frame.videoOn_cycles", cnt, 128);

    errz = 0; errm = 0;
    for (int s = 2; s <= NS; s++) begin
      if (!vo[s] && ci[s] != 0) errz++;
      if (vo[s] && ci[s] != {24'd0, fa[s-1][7:0]}) errm++;
    end
    chk("color_zero_when_blank", errz, 0);
    chk("color_follows_addr", errm, 0);

    // Advance to frame offset 130 = (h10, v5); fbAddr then shows (h9, v5) = 2*8 + 4.
    repeat (442 - NS) @(negedge vgaClk);
    chk("midframe_addr", 32'(fbAddr), 20);
    chk("midframe_videoOn", 32'(videoOn), 1);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge vgaClk);
      check_reset($sformatf("rst_mid%0d", k));
    end
    rst = 1'b0;
    capture(10);
    chk_start("restart");

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/frame_fetcher.md
# frame_fetcher

Upstream stage of the HDMI/VGA display path: generates 640x480@60 raster timing on `vgaClk` and reads one 8-bit palette index per displayed pixel from a synchronous framebuffer memory. Feeds the palette/pixel printer (`videoOn`, `color_index`) and drives `hsync`/`vsync` delayed to line up with the printer's RGB output. The framebuffer is stored at reduced resolution and pixel-replicated by `SCALE` in both axes.

## Interface
Parameters:
- `H_ACTIVE` 640, `H_FP` 16, `H_SYNC` 96, `H_BP` 48: horizontal timing in pixels.
- `V_ACTIVE` 480, `V_FP` 10, `V_SYNC` 2, `V_BP` 33: vertical timing in lines.
- `SCALE` 2: pixel replication factor (power of two).
- `FB_W` 320, `FB_H` 240: framebuffer dimensions in pixels.
- `ADDR_W` 17: framebuffer address width.
- `PRINTER_LAT` 2: downstream printer latency from `color_index` to RGB.
- `SYNC_ACTIVE` 0: sync pulse level. 0 means active-low.

Ports:
- `vgaClk` in 1: pixel clock (25.175 MHz nominal).
- `rst` in 1: reset, synchronous and active-high.
- `fbAddr` out ADDR_W: framebuffer read address. The memory has a registered read with 1-cycle latency.
- `fbData` in 8: read data, valid 1 cycle after `fbAddr`.
- `videoOn` out 1: high when `color_index` belongs to the active area.
- `color_index` out 8: palette index to the printer. Forced to 0 when `videoOn` is low.
- `hsync` out 1, `vsync` out 1: sync pulses, aligned to the printer's RGB.
- `frameStart` out 1: one-cycle pulse at raster position (0,0). Used for buffer swap.

## Operation
- Stage 0: counters `hCount` (0..H_TOTAL-1 = 799) and `vCount` (0..V_TOTAL-1 = 524).
  - `hCount` wraps 799→0 and increments `vCount` on that same edge.
  - `vCount` wraps 524→0.
- Address generation uses no multiplier.
  - `colCnt` increments every `SCALE` active pixels and clears at each line start.
  - `lineBase` adds `FB_W` after every `SCALE` completed active lines and clears at frame wrap.
  - `fbAddr` is registered as `lineBase + colCnt` (stage 1). It holds its last value outside the active area.
- Stage 2: `color_index = videoOn ? fbData : 0`.
  - `videoOn` is the active flag (`hCount<H_ACTIVE && vCount<V_ACTIVE`) delayed 2 cycles.
- Sync generation:
  - `hsync` is asserted for `hCount` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
  - `vsync` is asserted for `vCount` in [490,491].
  - Both are delayed 2+PRINTER_LAT = 4 cycles.
- `frameStart` is registered at stage 1 when the stage-0 position is (0,0).
- Elaboration check (`$error`): `FB_W*SCALE==H_ACTIVE`, `FB_H*SCALE==V_ACTIVE`, and `FB_W*FB_H <= 2**ADDR_W`.

## Timing
- Reset values, held for every cycle `rst` is sampled high:
  - counters 0, `colCnt`/`lineBase` 0, `fbAddr` 0, `videoOn` 0, `color_index` 0, `frameStart` 0.
  - `hsync`/`vsync` at the inactive level (1 for `SYNC_ACTIVE`=0).
  - All delay-line stages are cleared.
- After `rst` falls, the first cycle is raster (0,0). `frameStart` is 1 on the next cycle.
- Latency: raster position → `fbAddr` 1 cycle; → `color_index`/`videoOn` 2 cycles; → `hsync`/`vsync` 4 cycles.
- Reset mid-frame flushes the pipeline and no partial-frame output is produced. The raster restarts at (0,0).
- `fbAddr` for the last active pixel of the frame is `FB_W*FB_H-1` = 76799.
- Simultaneous h and v wrap at (799,524) clears `colCnt` and `lineBase` on the same edge.

## Structure
- Package `vga_pkg`: timing localparams, `H_TOTAL`/`V_TOTAL`, `SYNC_ACTIVE`, and the struct `{hCount, vCount, active, hs, vs}` passed down the delay line.
- Sub-module `vga_timing`: counters, active flag and raw sync generation.
- `frame_fetcher` itself contains the address generator and the alignment delay lines.

## Test plan
- Reset release → `frameStart`=1 exactly 1 cycle later; `fbAddr` 0,0,1,1,2 over the first active cycles (SCALE=2).
- Full line → `videoOn` high for exactly 640 cycles, starting 2 cycles after `hCount`=0. `hsync` low for 96 cycles, starting at cycle 656+4 of the line.
- Lines 0 and 1 both start at `fbAddr`=0 and line 2 starts at 320. Line 479 ends at 76799. Next frame restarts at 0.
- Memory model returning `addr[7:0]` → `color_index` matches `fbAddr` 1 cycle earlier. `color_index`=0 whenever `videoOn`=0.
- Whole frame → 800*525 = 420000 cycles between `frameStart` pulses. `vsync` low for 1600 cycles.
- `rst` asserted at (300,200) for 3 cycles → outputs hold reset values during reset. The raster restarts at (0,0) and `fbAddr` sequence repeats from 0.
